// File: rtl/sel_mem_pkg.sv
// rtl/sel_mem_pkg.sv - shared types and helpers for the memory-select sequencer
// Purpose: FSM state encoding plus index arithmetic used by the sequencer and
// its index counter.
// Contents:
//   state_t   - sequencer FSM states (IDLE, RUN, FIN)
//   next_idx  - successor of an index, wrapping from depth-1 back to 0
//   in_range  - 1 when an index is a legal memory number for a given depth
package sel_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic int unsigned next_idx(int unsigned cur, int unsigned depth);
    return (cur == depth - 1) ? 0 : cur + 1;
  endfunction

  // Done at 32 bits so the check stays meaningful when DEPTH == 2**SEL_W.
  function automatic logic in_range(int unsigned v, int unsigned depth);
    return v < depth;
  endfunction

endpackage

// File: rtl/sel_mem_idx_ctr.sv
// rtl/sel_mem_idx_ctr.sv - wrapping select-index counter with load/advance/hold
// Purpose: holds the current memory-select index. Load has priority over
// advance; advance steps modulo DEPTH; otherwise the index holds.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset (index -> 0)
//   en             - clock enable, index holds when 0
//   ld, ld_val     - load ld_val at the next enabled edge
//   adv            - step to the next index (wraps DEPTH-1 -> 0)
//   idx            - current index
module sel_mem_idx_ctr
  import sel_mem_pkg::*;
#(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld,
  input  logic [SEL_W-1:0] ld_val,
  input  logic             adv,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (ld) begin
      idx_d = ld_val;
    end else if (adv) begin
      idx_d = SEL_W'(next_idx(32'(idx_q), DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (en) begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/sel_mem_seq.sv
// rtl/sel_mem_seq.sv - memory-bank select register with autonomous range sweep
// Purpose: drives the weight/activation memory select lines. In IDLE it acts
// as a plain select register (load); start sweeps data_in..last_idx (wrapping
// modulo DEPTH) handing each index out through a valid/ready handshake, with
// optional looping and abort.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   en                  - global enable; all state and outputs hold when 0
//   load, data_in       - direct write of data_in (IDLE only)
//   start, last_idx     - sweep from data_in to last_idx
//   loop                - captured at start; restart the sweep after last_idx
//   abort               - stop a running sweep without done
//   ready               - consumer accepts sel_out
//   sel_out, sel_valid  - current index / index is a sweep element
//   busy                - not IDLE
//   done, err           - one-cycle pulses: last index accepted / command rejected
module sel_mem_seq
  import sel_mem_pkg::*;
#(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [SEL_W-1:0] data_in,
  input  logic             start,
  input  logic [SEL_W-1:0] last_idx,
  input  logic             loop,
  input  logic             abort,
  input  logic             ready,
  output logic [SEL_W-1:0] sel_out,
  output logic             sel_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] first_q, first_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             loop_q, loop_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             ctr_ld, ctr_adv;
  logic [SEL_W-1:0] ctr_val;
  logic             data_ok, last_ok, at_last;

  assign data_ok = in_range(32'(data_in), DEPTH);
  assign last_ok = in_range(32'(last_idx), DEPTH);
  assign at_last = (sel_out == last_q);

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    last_d  = last_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ctr_ld  = 1'b0;
    ctr_adv = 1'b0;
    ctr_val = data_in;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (data_ok && last_ok) begin
            first_d = data_in;
            last_d  = last_idx;
            loop_d  = loop;
            ctr_ld  = 1'b1;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end else if (load) begin
          if (data_ok) begin
            ctr_ld = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Commands are rejected while sweeping but the sweep itself carries on.
        err_d = start | load;
        // Abort outranks the handshake: the element on the bus is not accepted.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ready) begin
          if (at_last) begin
            done_d = 1'b1;
            if (loop_q) begin
              ctr_ld  = 1'b1;
              ctr_val = first_q;
            end else begin
              state_d = ST_FIN;
            end
          end else begin
            ctr_adv = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      first_q <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      first_q <= first_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  sel_mem_idx_ctr #(
    .SEL_W(SEL_W),
    .DEPTH(DEPTH)
  ) u_idx_ctr (
    .clk   (clk),
    .rst_n (rst),
    .en    (en),
    .ld    (ctr_ld),
    .ld_val(ctr_val),
    .adv   (ctr_adv),
    .idx   (sel_out)
  );

  // sel_valid is a pure state decode so the asynchronous reset drops it at once.
  assign sel_valid = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sel_mem_seq.sv
// tb/tb_sel_mem_seq.sv - self-checking bench for sel_mem_seq (DEPTH 16 and 12)
module tb_sel_mem_seq;

  logic       clk = 1'b0;
  logic       rst, en, load, start, loop, abort, ready;
  logic [3:0] data_in, last_idx;
  logic [3:0] sel16, sel12;
  logic       v16, v12, b16, b12, d16, d12, e16, e12;

  always #5 clk = ~clk;

  sel_mem_seq #(.SEL_W(4), .DEPTH(16)) u16 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in), .start(start),
    .last_idx(last_idx), .loop(loop), .abort(abort), .ready(ready),
    .sel_out(sel16), .sel_valid(v16), .busy(b16), .done(d16), .err(e16)
  );

  sel_mem_seq #(.SEL_W(4), .DEPTH(12)) u12 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in), .start(start),
    .last_idx(last_idx), .loop(loop), .abort(abort), .ready(ready),
    .sel_out(sel12), .sel_valid(v12), .busy(b12), .done(d12), .err(e12)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sweep is the list of indices still to be handed out.
  int m_depth[2] = '{16, 12};
  int m_mode[2];   // 0 idle, 1 sweeping, 2 finishing
  int m_sel[2], m_first[2], m_last[2];
  bit m_loop[2], m_done[2], m_err[2];
  int m_q[2][$];

  function automatic void build(int k, int f, int l);
    int i = f;
    m_q[k].delete();
    for (int n = 0; n < m_depth[k]; n++) begin
      m_q[k].push_back(i);
      if (i == l) break;
      i = (i + 1) % m_depth[k];
    end
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_sel[k] = 0; m_first[k] = 0; m_last[k] = 0;
      m_loop[k] = 0; m_done[k] = 0; m_err[k] = 0;
      m_q[k].delete();
    end
  endfunction

  function automatic void m_step();
    for (int k = 0; k < 2; k++) begin
      if (en) begin
        m_done[k] = 0;
        m_err[k]  = 0;
        if (m_mode[k] == 0) begin
          if (start) begin
            if (int'(data_in) < m_depth[k] && int'(last_idx) < m_depth[k]) begin
              m_first[k] = data_in; m_last[k] = last_idx; m_loop[k] = loop;
              build(k, m_first[k], m_last[k]);
              m_sel[k]  = data_in;
              m_mode[k] = 1;
            end else m_err[k] = 1;
          end else if (load) begin
            if (int'(data_in) < m_depth[k]) m_sel[k] = data_in;
            else m_err[k] = 1;
          end
        end else if (m_mode[k] == 1) begin
          if (start || load) m_err[k] = 1;
          if (abort) m_mode[k] = 0;
          else if (ready) begin
            void'(m_q[k].pop_front());
            if (m_q[k].size() == 0) begin
              m_done[k] = 1;
              if (m_loop[k]) build(k, m_first[k], m_last[k]);
              else m_mode[k] = 2;
            end
            if (m_mode[k] == 1) m_sel[k] = m_q[k][0];
          end
        end else begin
          m_mode[k] = 0;
        end
      end
    end
  endfunction

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] s;
      logic v, b, d, e;
      string t;
      if (k == 0) begin s = sel16; v = v16; b = b16; d = d16; e = e16; t = "d16"; end
      else        begin s = sel12; v = v12; b = b12; d = d12; e = e12; t = "d12"; end
      chk({t, "_sel_out"},   s, m_sel[k]);
      chk({t, "_sel_valid"}, v, m_mode[k] == 1);
      chk({t, "_busy"},      b, m_mode[k] != 0);
      chk({t, "_done"},      d, m_done[k]);
      chk({t, "_err"},       e, m_err[k]);
    end
  endtask

  task automatic set(bit e, bit ld, bit st, bit lp, bit ab, bit rd, logic [3:0] d, logic [3:0] l);
    en = e; load = ld; start = st; loop = lp; abort = ab; ready = rd;
    data_in = d; last_idx = l;
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    bit en, load, start, loop, abort, ready;
    logic [3:0] d, l;
    logic [3:0] sel;
    bit v, b, dn, er;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b0;
    set(1, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    // Expected outputs of the DEPTH=16 instance after each edge.
    tbl.push_back('{1,1,0,0,0,0, 5, 0,  5,0,0,0,0});  // load 5
    tbl.push_back('{0,1,0,0,0,0, 3, 0,  5,0,0,0,0});  // load 3 with en=0
    tbl.push_back('{1,0,0,0,0,0, 3, 0,  5,0,0,0,0});
    tbl.push_back('{1,0,1,0,0,1, 2, 5,  2,1,1,0,0});  // sweep 2..5
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  3,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  4,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  5,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  5,0,1,1,0});  // FIN + done
    tbl.push_back('{1,0,0,0,0,0, 0, 0,  5,0,0,0,0});  // IDLE
    tbl.push_back('{1,0,1,0,0,0,14, 1, 14,1,1,0,0});  // wrap 14..1
    tbl.push_back('{1,0,0,0,0,1, 0, 0, 15,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,0, 0, 0, 15,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  0,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,0, 0, 0,  0,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  1,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,0, 0, 0,  1,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  1,0,1,1,0});
    tbl.push_back('{1,0,0,0,0,0, 0, 0,  1,0,0,0,0});
    tbl.push_back('{1,0,1,1,0,1, 3, 4,  3,1,1,0,0});  // loop 3..4
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  4,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  3,1,1,1,0});
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  4,1,1,0,0});
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  3,1,1,1,0});
    tbl.push_back('{1,0,0,0,1,1, 0, 0,  3,0,0,0,0});  // abort beats handshake
    tbl.push_back('{1,0,0,0,1,0, 0, 0,  3,0,0,0,0});  // abort in IDLE
    tbl.push_back('{1,0,1,0,0,1, 7, 7,  7,1,1,0,0});  // single element
    tbl.push_back('{1,0,0,0,0,1, 0, 0,  7,0,1,1,0});
    tbl.push_back('{0,0,0,0,0,1, 0, 0,  7,0,1,1,0});  // en=0 holds the pulse
    tbl.push_back('{1,0,0,0,0,0, 0, 0,  7,0,0,0,0});

    repeat (2) @(negedge clk);
    chk("rst_sel_out", sel16, 0);
    chk("rst_valid", v16, 0);
    chk("rst_busy", b16, 0);
    compare_model();
    rst = 1'b1;

    foreach (tbl[i]) begin
      set(tbl[i].en, tbl[i].load, tbl[i].start, tbl[i].loop, tbl[i].abort,
          tbl[i].ready, tbl[i].d, tbl[i].l);
      cycle();
      chk($sformatf("vec%0d_sel_out", i), sel16, tbl[i].sel);
      chk($sformatf("vec%0d_valid", i), v16, tbl[i].v);
      chk($sformatf("vec%0d_busy", i), b16, tbl[i].b);
      chk($sformatf("vec%0d_done", i), d16, tbl[i].dn);
      chk($sformatf("vec%0d_err", i), e16, tbl[i].er);
    end

    // Rejected commands on the DEPTH=12 instance.
    set(1, 0, 1, 0, 0, 0, 2, 13); cycle();
    chk("e12_start_oob_err", e12, 1);
    chk("e12_start_oob_busy", b12, 0);
    chk("e12_start_oob_sel", sel12, 7);
    set(1, 0, 0, 0, 1, 0, 0, 0); cycle();
    chk("e12_err_pulse_clear", e12, 0);
    set(1, 1, 0, 0, 0, 0, 12, 0); cycle();
    chk("e12_load_oob_err", e12, 1);
    chk("e12_load_oob_sel", sel12, 7);
    set(1, 0, 1, 0, 0, 0, 1, 3); cycle();
    chk("e12_start_ok_sel", sel12, 1);
    chk("e12_start_ok_err", e12, 0);
    set(1, 0, 1, 0, 0, 1, 5, 6); cycle();
    chk("e12_start_busy_err", e12, 1);
    chk("e12_start_busy_sel", sel12, 2);
    chk("e12_start_busy_valid", v12, 1);
    set(1, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) cycle();
    chk("e12_sweep_end_busy", b12, 0);
    chk("e12_sweep_end_sel", sel12, 3);

    // Asynchronous reset between edges mid-sweep.
    set(1, 0, 1, 0, 0, 1, 4, 9); cycle();
    set(1, 0, 0, 0, 0, 1, 0, 0); cycle();
    chk("ar_pre_sel", sel16, 5);
    #2 rst = 1'b0;
    #1;
    chk("ar_sel_out", sel16, 0);
    chk("ar_valid", v16, 0);
    chk("ar_busy", b16, 0);
    chk("ar_done", d16, 0);
    m_reset();
    compare_model();
    @(negedge clk) rst = 1'b1;

    // Random traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      set($urandom_range(7) != 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
          $urandom_range(1) == 1, $urandom_range(15) == 0, $urandom_range(1) == 1,
          4'($urandom_range(15)), 4'($urandom_range(15)));
      cycle();
      if ($urandom_range(399) == 0) begin
        #2 rst = 1'b0;
        #1;
        m_reset();
        compare_model();
        @(negedge clk) rst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sel_mem_seq.md
Name: sel_mem_seq

Overview:
Parametrised successor to the 4-bit memory-select register. Holds a memory-bank select index and can also step it autonomously across a programmed bank range, with a valid/ready handshake, wrap-around, loop mode and abort. It sits between the autoencoder layer controller and the weight/activation memory muxes, and drives the select lines during layer sweeps.

Parameters:
SEL_W, 4, width of the select index
DEPTH, 16, number of selectable memories; legal index range 0..DEPTH-1, with DEPTH <= 2**SEL_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  global clock enable; when 0, all state and outputs hold
load  in  1  direct write of data_in to sel_out (IDLE only)
data_in  in  SEL_W  direct-load value, and first index for start
start  in  1  begin a sweep from data_in to last_idx
last_idx  in  SEL_W  final index of the sweep
loop  in  1  sampled at start; 1 means restart the sweep after the last index
abort  in  1  terminate a running sweep
ready  in  1  consumer accepts the current sel_out
sel_out  out  SEL_W  current select index
sel_valid  out  1  sel_out is a sweep element awaiting acceptance
busy  out  1  FSM is not in IDLE
done  out  1  one-cycle pulse when the last index is accepted
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (rst=0, asynchronous): sel_out=0, sel_valid=0, busy=0, done=0, err=0, FSM=IDLE, and internal first_q, last_q and loop_q are cleared.
- en=0: nothing updates. Pulses (done, err) are cleared on the next en=1 edge, not held high beyond it.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - Priority is start > load.
  - load with data_in < DEPTH: sel_out <= data_in at the next edge. This is the legacy register behaviour, with 1-cycle latency.
  - start with data_in < DEPTH and last_idx < DEPTH: capture first_q, last_q and loop_q; sel_out <= data_in; sel_valid <= 1; go to RUN.
  - Any load or start with an out-of-range operand is ignored and pulses err for one cycle. State is unchanged.
- RUN:
  - busy=1 and sel_valid=1.
  - sel_out is stable while ready=0.
  - On a sel_valid & ready edge, if sel_out != last_q: sel_out <= (sel_out == DEPTH-1) ? 0 : sel_out+1. Ranges wrap modulo DEPTH, so first > last is legal. Example: 14,15,0,1 with DEPTH=16.
  - On a sel_valid & ready edge with sel_out == last_q and loop_q=1: pulse done, sel_out <= first_q, stay in RUN.
  - On a sel_valid & ready edge with sel_out == last_q and loop_q=0: pulse done, sel_valid <= 0, sel_out holds last_q, go to FIN.
  - A sweep with first == last yields exactly one element.
- FIN: a single cycle with busy=1; then go to IDLE. start, load and abort are ignored in FIN and do not raise err.
- abort in RUN:
  - Next edge: sel_valid=0, go to IDLE, no done pulse, sel_out holds its current value.
  - abort wins over a simultaneous handshake; that element is treated as not accepted.
  - abort in IDLE is a no-op.
- start or load while busy: ignored, and err pulses (RUN only).
- Throughput is 1 index per cycle while ready is held high.
- Asserting rst mid-sweep drops sel_valid immediately (asynchronously). No done pulse is produced.

Decomposition:
- Shared package sel_mem_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2);
  - a function that computes next_idx(cur, DEPTH) with wrap.
- One natural sub-module, sel_mem_idx_ctr: the wrapping index counter with load, advance and hold. The FSM, handshake and error logic stay in the top.

Test Plan:
- Reset/load: rst low then high, en=1, load data_in=5 -> sel_out=5 after 1 cycle, busy=0; load data_in=3 with en=0 -> sel_out stays 5.
- Basic sweep: start data_in=2 last_idx=5, loop=0, ready=1 -> sel_out 2,3,4,5 on consecutive cycles with sel_valid=1; done pulses on the cycle after 5 is accepted; FIN then IDLE; sel_out=5.
- Wrap plus backpressure: start 14->1, ready toggling 1,0,1,... -> sequence 14,15,0,1; each value held during ready=0; exactly one done.
- Loop and abort: start 3->4 with loop=1, ready=1 -> 3,4,3,4...; done pulses after each 4; abort -> sel_valid=0 next cycle, IDLE, no done.
- Errors, with DEPTH=12: start last_idx=13 -> err pulse, stays IDLE; load data_in=12 -> err; start while in RUN -> err, sweep unaffected.
- Async reset mid-sweep: rst=0 between clock edges -> sel_valid, busy and sel_out go to 0 immediately, with no done.
